midi_parser: RTL

MIDI_PARSER -- requirements
Module: midi_parser

---
 rtl/midi_parser.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: turns channel-voice messages (with running status) into
// registered one-cycle event strobes, skipping real-time, system common and SysEx traffic.
module midi_parser #(
    parameter int         OMNI    = 1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       byte_valid,
    input  logic [7:0] midi_byte,
    output logic       event_valid,
    output logic [2:0] event_type,
    output logic [3:0] event_chan,
    output logic [6:0] event_d1,
    output logic [6:0] event_d2,
    output logic       sync_error
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SYSEX
    } state_t;

    localparam logic [2:0] TYPE_NOTE_OFF = 3'd0;
    localparam logic [2:0] TYPE_NOTE_ON  = 3'd1;
    localparam logic [2:0] TYPE_PROG     = 3'd4;
    localparam logic [2:0] TYPE_CHAN_AT  = 3'd5;

    state_t     state_reg, state_next;
    logic [2:0] run_type_reg, run_type_next;
    logic [3:0] run_chan_reg, run_chan_next;
    logic [6:0] d1_reg, d1_next;

    logic       event_valid_reg, event_valid_next;
    logic [2:0] event_type_reg, event_type_next;
    logic [3:0] event_chan_reg, event_chan_next;
    logic [6:0] event_d1_reg, event_d1_next;
    logic [6:0] event_d2_reg, event_d2_next;
    logic       sync_error_reg, sync_error_next;

    logic       is_realtime;
    logic       is_chan_status;
    logic       is_data;
    logic       two_data_bytes;
    logic       chan_match;
    logic       emit;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;

    assign is_realtime    = (midi_byte >= 8'hF8);
    assign is_chan_status = midi_byte[7] && (midi_byte[7:4] != 4'hF);
    assign is_data        = !midi_byte[7];
    assign two_data_bytes = (run_type_reg != TYPE_PROG) && (run_type_reg != TYPE_CHAN_AT);
    assign chan_match     = (OMNI != 0) || (run_chan_reg == CHANNEL);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            run_type_reg    <= 3'd0;
            run_chan_reg    <= 4'd0;
            d1_reg          <= 7'd0;
            event_valid_reg <= 1'b0;
            event_type_reg  <= 3'd0;
            event_chan_reg  <= 4'd0;
            event_d1_reg    <= 7'd0;
            event_d2_reg    <= 7'd0;
            sync_error_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_type_reg    <= run_type_next;
            run_chan_reg    <= run_chan_next;
            d1_reg          <= d1_next;
            event_valid_reg <= event_valid_next;
            event_type_reg  <= event_type_next;
            event_chan_reg  <= event_chan_next;
            event_d1_reg    <= event_d1_next;
            event_d2_reg    <= event_d2_next;
            sync_error_reg  <= sync_error_next;
        end
    end

    // Byte classification and state transitions; emit/emit_d* describe a completed message.
    always_comb begin
        state_next      = state_reg;
        run_type_next   = run_type_reg;
        run_chan_next   = run_chan_reg;
        d1_next         = d1_reg;
        sync_error_next = 1'b0;
        emit            = 1'b0;
        emit_d1         = d1_reg;
        emit_d2         = 7'd0;

        if (byte_valid && !is_realtime) begin
            if (is_chan_status) begin
                // A status byte arriving with d1 already held abandons that message.
                sync_error_next = (state_reg == WAIT_D2);
                run_type_next   = midi_byte[6:4];
                run_chan_next   = midi_byte[3:0];
                state_next      = WAIT_D1;
            end else if (midi_byte == 8'hF0) begin
                run_type_next = 3'd0;
                run_chan_next = 4'd0;
                state_next    = SYSEX;
            end else if (!is_data) begin
                if (state_reg == SYSEX) begin
                    if (midi_byte == 8'hF7) begin
                        state_next = IDLE;
                    end
                end else begin
                    run_type_next = 3'd0;
                    run_chan_next = 4'd0;
                    state_next    = IDLE;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        sync_error_next = 1'b1;
                    end
                    WAIT_D1: begin
                        if (two_data_bytes) begin
                            d1_next    = midi_byte[6:0];
                            state_next = WAIT_D2;
                        end else begin
                            emit    = 1'b1;
                            emit_d1 = midi_byte[6:0];
                        end
                    end
                    WAIT_D2: begin
                        emit       = 1'b1;
                        emit_d2    = midi_byte[6:0];
                        state_next = WAIT_D1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Event register: fields only change when an accepted event is presented.
    always_comb begin
        event_valid_next = 1'b0;
        event_type_next  = event_type_reg;
        event_chan_next  = event_chan_reg;
        event_d1_next    = event_d1_reg;
        event_d2_next    = event_d2_reg;

        if (emit && chan_match) begin
            event_valid_next = 1'b1;
            event_chan_next  = run_chan_reg;
            event_d1_next    = emit_d1;
            event_d2_next    = emit_d2;
            if ((run_type_reg == TYPE_NOTE_ON) && (emit_d2 == 7'd0)) begin
                event_type_next = TYPE_NOTE_OFF;
            end else begin
                event_type_next = run_type_reg;
            end
        end
    end

    assign event_valid = event_valid_reg;
    assign event_type  = event_type_reg;
    assign event_chan  = event_chan_reg;
    assign event_d1    = event_d1_reg;
    assign event_d2    = event_d2_reg;
    assign sync_error  = sync_error_reg;

endmodule
